// File: rtl/regfile_2r1w_pkg.sv
// Shared sizing constants for the 2-read/1-write register file.
package regfile_2r1w_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_2r1w_register32_ar.sv
// Word register with load enable and asynchronous active-low clear.
module register32_ar
  import regfile_2r1w_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 register file: one write port, two registered read ports with
// same-cycle write forwarding; entry 0 reads as zero and ignores writes.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b
);
  logic [DATA_W-1:0] w_entry [NUM_REGS];
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic              r_rvalid_a;
  logic              r_rvalid_b;

  // Entry 0 has no storage; the mux reads a constant zero there.
  assign w_entry[ZERO_REG] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    logic w_wen;
    assign w_wen = we && (waddr == ADDR_W'(i));
    register32_ar u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_wen),
      .i_d   (wdata),
      .o_q   (w_entry[i])
    );
  end

  // Zero register wins over forwarding so a write to r0 never leaks out.
  always_comb begin
    w_sel_a = w_entry[raddr_a];
    if (raddr_a == ADDR_W'(ZERO_REG)) begin
      w_sel_a = '0;
    end else if (we && (waddr == raddr_a)) begin
      w_sel_a = wdata;
    end
  end

  always_comb begin
    w_sel_b = w_entry[raddr_b];
    if (raddr_b == ADDR_W'(ZERO_REG)) begin
      w_sel_b = '0;
    end else if (we && (waddr == raddr_b)) begin
      w_sel_b = wdata;
    end
  end

  register32_ar u_rdata_a (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (re_a),
    .i_d   (w_sel_a),
    .o_q   (rdata_a)
  );

  register32_ar u_rdata_b (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (re_b),
    .i_d   (w_sel_b),
    .o_q   (rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_a <= re_a;
      r_rvalid_b <= re_b;
    end
  end

  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: driver pushes expected responses,
// a negedge monitor pops them against rvalid/rdata on each port.
module tb_regfile_2r1w;
  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re_a;
  logic [4:0]  raddr_a;
  logic [31:0] rdata_a;
  logic        rvalid_a;
  logic        re_b;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_b;
  logic        rvalid_b;

  logic [31:0] exp_qa[$];
  logic [31:0] exp_qb[$];
  logic        rva_q[$];
  logic        rvb_q[$];
  logic [31:0] hold_a;
  logic [31:0] hold_b;
  logic [31:0] model [32];
  int          n_checks;
  int          n_fail;

  regfile_2r1w dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re_a     (re_a),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .rvalid_a (rvalid_a),
    .re_b     (re_b),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .rvalid_b (rvalid_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_scoreboard();
    exp_qa.delete();
    exp_qb.delete();
    rva_q.delete();
    rvb_q.delete();
    hold_a = '0;
    hold_b = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // driver: one clock cycle of stimulus with the responses it should produce
  task automatic do_cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                          input logic ra_en, input logic [4:0] ra,
                          input logic rb_en, input logic [4:0] rb,
                          input logic [31:0] ea, input logic [31:0] eb);
    we = w; waddr = wa; wdata = wd;
    re_a = ra_en; raddr_a = ra;
    re_b = rb_en; raddr_b = rb;
    @(posedge clk);
    rva_q.push_back(ra_en);
    rvb_q.push_back(rb_en);
    if (ra_en) exp_qa.push_back(ea);
    if (rb_en) exp_qb.push_back(eb);
    #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] model_sel(input logic [4:0] a, input logic w,
                                            input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (w && wa == a) return wd;
    return model[a];
  endfunction

  // monitor: rvalid must match the request of the previous edge, rdata the
  // popped value when valid and the last delivered value otherwise
  always @(negedge clk) begin
    if (rst_n && rva_q.size() > 0) begin
      logic e_v;
      e_v = rva_q.pop_front();
      check("rvalid_a", {31'b0, rvalid_a}, {31'b0, e_v});
      if (e_v) hold_a = exp_qa.pop_front();
      check("rdata_a", rdata_a, hold_a);
    end
    if (rst_n && rvb_q.size() > 0) begin
      logic e_v;
      e_v = rvb_q.pop_front();
      check("rvalid_b", {31'b0, rvalid_b}, {31'b0, e_v});
      if (e_v) hold_b = exp_qb.pop_front();
      check("rdata_b", rdata_b, hold_b);
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_scoreboard();
    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
    #1;
    check("reset_rdata_a", rdata_a, 32'h0);
    check("reset_rdata_b", rdata_b, 32'h0);
    check("reset_rvalid", {30'b0, rvalid_a, rvalid_b}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // every address reads zero after reset, then valid drops when idle
    for (int i = 0; i < 32; i++)
      do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i), 32'h0, 32'h0);
    idle();

    // write then read on both ports
    do_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0);
    do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    idle();

    // forwarding, then a read from storage, with B holding its old value
    do_cycle(1'b1, 5'd9, 32'h12345678, 1'b1, 5'd9, 1'b1, 5'd5, 32'h12345678, 32'hDEADBEEF);
    do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h12345678, 32'h0);
    // forwarding on B while A reads the old contents of another entry
    do_cycle(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd9, 1'b1, 5'd5, 32'h12345678, 32'hCAFEF00D);

    // register zero ignores writes, including a forwarding attempt
    do_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0);
    do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0);
    do_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0);

    // fill r1..r31 with i*0x01010101 and spot-check
    for (int i = 1; i < 32; i++)
      do_cycle(1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0);
    do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd31, 32'h07070707, 32'h1F1F1F1F);
    @(negedge clk);

    // 3 ns reset pulse mid-cycle with a read request still asserted
    #1 rst_n = 1'b0;
    clear_scoreboard();
    #1;
    check("midreset_rdata_a", rdata_a, 32'h0);
    check("midreset_rdata_b", rdata_b, 32'h0);
    check("midreset_rvalid", {30'b0, rvalid_a, rvalid_b}, 32'h0);
    #2 rst_n = 1'b1;
    // the first edge after release is a normal cycle
    for (int i = 0; i < 32; i++)
      do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i), 32'h0, 32'h0);
    idle();

    // interleaved random traffic against the array model
    for (int n = 0; n < 3000; n++) begin
      logic        w, ea_en, eb_en;
      logic [4:0]  wa, ra, rb;
      logic [31:0] wd;
      w     = 1'($urandom_range(0, 1));
      wa    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rb    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wd    = $urandom;
      ea_en = ($urandom_range(0, 3) != 0);
      eb_en = ($urandom_range(0, 3) != 0);
      do_cycle(w, wa, wd, ea_en, ra, eb_en, rb,
               model_sel(ra, w, wa, wd), model_sel(rb, w, wa, wd));
      if (w && wa != 5'd0) model[wa] = wd;
    end
    idle();
    @(negedge clk);
    #1;
    check("drain", 32'(exp_qa.size() + exp_qb.size() + rva_q.size() + rvb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
